// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-AXI3 bridge: FSM encodings, master indices and AXI tie-offs.
// The optional BRIDGE_RAW_FINE_EN build only changes logic in cpu_axi_bridge.sv.
package bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } wr_state_t;

    localparam logic M_INST = 1'b0;
    localparam logic M_DATA = 1'b1;

    // Constant AXI fields, driven outside the bridge: single-beat 32-bit INCR with id 0.
    localparam logic [3:0] AXI_ID    = 4'd0;
    localparam logic [3:0] AXI_LEN   = 4'd0;
    localparam logic [2:0] AXI_SIZE  = 3'b010;
    localparam logic [1:0] AXI_BURST = 2'b01;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/bridge_wr_fsm.sv
// Write channel tracker for the bridge: issues AW and W together, each dropping after its
// own handshake, then waits for B. The current state is exported for debug and checkers.
module bridge_wr_fsm
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [3:0]  strb,
    input  logic [31:0] data,
    input  logic        awready,
    input  logic        wready,
    input  logic        bvalid,
    output logic        awvalid,
    output logic        wvalid,
    output logic        bready,
    output logic        done,
    output logic        idle,
    output logic [31:0] awaddr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output wr_state_t   state
);

    wr_state_t state_next;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;

    // Valid/ready: a channel transfers on a cycle where both are high; valid never
    // waits on ready and payload registers stay frozen while valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state     <= state_next;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awaddr <= '0;
            wdata  <= '0;
            wstrb  <= '0;
        end else if (start && state == W_IDLE) begin
            awaddr <= word_align(addr);
            wdata  <= data;
            wstrb  <= strb;
        end
    end

    always_comb begin
        state_next = state;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        done       = 1'b0;
        case (state)
            W_IDLE: begin
                if (start) begin
                    state_next = W_AW;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            W_AW: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_next = W_B;
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    done       = 1'b1;
                    state_next = W_IDLE;
                end
            end
            default: state_next = W_IDLE;
        endcase
    end

    assign idle = (state == W_IDLE);

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU's inst/data sram-like ports onto one AXI3 master, one read and one write in flight.
// Define BRIDGE_RAW_FINE_EN to block data reads only when they hit the pending write's word.
module cpu_axi_bridge
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  wr,
    input  logic [63:0] addr,
    input  logic [7:0]  wstrb,
    input  logic [63:0] wdata,
    output logic [1:0]  addr_ok,
    output logic [1:0]  data_ok,
    output logic [31:0] rdata,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic        axi_bvalid,
    output logic        axi_bready
);

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state;
    logic      rd_owner;
    logic      rd_idle, wr_idle, wr_done;
    logic      inst_req, data_rd_req, data_wr_req, raw_block;
    logic      inst_rd_ok, data_rd_ok, data_wr_ok;
    logic      unused_bits;

    assign inst_req    = req[M_INST] & ~wr[M_INST];
    assign data_rd_req = req[M_DATA] & ~wr[M_DATA];
    assign data_wr_req = req[M_DATA] &  wr[M_DATA];
    assign rd_idle     = (rd_state == R_IDLE);
    assign unused_bits = ^{wstrb[3:0], wdata[31:0]};

`ifdef BRIDGE_RAW_FINE_EN
    assign raw_block = ~wr_idle && (addr[63:34] == axi_awaddr[31:2]);
`else
    assign raw_block = ~wr_idle;
`endif

    // Data wins the read port; a blocked data read must not starve inst fetch.
    assign data_rd_ok = rd_idle & data_rd_req & ~raw_block;
    assign inst_rd_ok = rd_idle & inst_req & ~data_rd_ok;
    assign data_wr_ok = data_wr_req & wr_idle & ~(~rd_idle & (rd_owner == M_DATA));
    assign addr_ok    = {data_rd_ok | data_wr_ok, inst_rd_ok};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state   <= R_IDLE;
            rd_owner   <= M_INST;
            axi_araddr <= '0;
        end else begin
            rd_state <= rd_next;
            if (data_rd_ok || inst_rd_ok) begin
                rd_owner   <= data_rd_ok ? M_DATA : M_INST;
                axi_araddr <= word_align(data_rd_ok ? addr[63:32] : addr[31:0]);
            end
        end
    end

    always_comb begin
        rd_next     = rd_state;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        data_ok     = {wr_done, 1'b0};
        case (rd_state)
            R_IDLE: if (data_rd_ok || inst_rd_ok) rd_next = R_AR;
            R_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) rd_next = R_R;
            end
            R_R: begin
                axi_rready = 1'b1;
                data_ok[rd_owner] = axi_rvalid;
                if (axi_rvalid) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign rdata = axi_rdata;

    bridge_wr_fsm u_wr_fsm (
        .clk     (clk),
        .rst     (reset),
        .start   (data_wr_ok),
        .addr    (addr[63:32]),
        .strb    (wstrb[7:4]),
        .data    (wdata[63:32]),
        .awready (axi_awready),
        .wready  (axi_wready),
        .bvalid  (axi_bvalid),
        .awvalid (axi_awvalid),
        .wvalid  (axi_wvalid),
        .bready  (axi_bready),
        .done    (wr_done),
        .idle    (wr_idle),
        .awaddr  (axi_awaddr),
        .wdata   (axi_wdata),
        .wstrb   (axi_wstrb),
        .state   (wr_state)
    );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: cycle-by-cycle stimulus with hand-computed expectations.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [63:0] addr;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [1:0]  addr_ok;
    logic [1:0]  data_ok;
    logic [31:0] rdata;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic        axi_bvalid;
    logic        axi_bready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_axi_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .wr          (wr),
        .addr        (addr),
        .wstrb       (wstrb),
        .wdata       (wdata),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok),
        .rdata       (rdata),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive just after the rising edge; sample on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req = 2'b00; wr = 2'b00; addr = '0; wstrb = '0; wdata = '0;
        axi_arready = 1'b0; axi_rdata = '0; axi_rvalid = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    endtask

    task automatic inst_read(input string tag, input logic [31:0] a, input logic [31:0] d);
        cyc(); req = 2'b01; wr = 2'b00; addr = {32'h0, a};
        smp(); check({tag, "_addr_ok"}, 32'(addr_ok), 32'h1);
        cyc(); req = 2'b00; axi_arready = 1'b1;
        smp(); check({tag, "_arvalid"}, 32'(axi_arvalid), 32'h1);
        check({tag, "_araddr"}, axi_araddr, {a[31:2], 2'b00});
        cyc(); axi_arready = 1'b0;
        smp(); check({tag, "_arvalid_drop"}, 32'(axi_arvalid), 32'h0);
        check({tag, "_no_early_ok"}, 32'(data_ok), 32'h0);
        cyc(); axi_rvalid = 1'b1; axi_rdata = d;
        smp(); check({tag, "_data_ok"}, 32'(data_ok), 32'h1);
        check({tag, "_rdata"}, rdata, d);
        cyc(); axi_rvalid = 1'b0;
        smp(); check({tag, "_single_pulse"}, 32'(data_ok), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        smp();
        check("rst_arvalid", 32'(axi_arvalid), 32'h0);
        check("rst_awvalid", 32'(axi_awvalid), 32'h0);
        check("rst_wvalid",  32'(axi_wvalid), 32'h0);
        check("rst_rready",  32'(axi_rready), 32'h0);
        check("rst_bready",  32'(axi_bready), 32'h0);
        check("rst_data_ok", 32'(data_ok), 32'h0);
        check("rst_araddr",  axi_araddr, 32'h0);
        check("rst_awaddr",  axi_awaddr, 32'h0);
        check("rst_wdata",   axi_wdata, 32'h0);
        check("rst_wstrb",   32'(axi_wstrb), 32'h0);
        reset = 1'b0;

        // 1: single inst read
        inst_read("s1", 32'h1c000000, 32'h02800c0c);

        // 2: simultaneous inst and data read, data first
        cyc(); req = 2'b11; wr = 2'b00; addr = {32'h1c020000, 32'h1c000010};
        smp(); check("s2_prio", 32'(addr_ok), 32'h2);
        cyc(); req = 2'b01; axi_arready = 1'b1;
        smp(); check("s2_inst_wait_ar", 32'(addr_ok), 32'h0);
        check("s2_d_araddr", axi_araddr, 32'h1c020000);
        cyc(); axi_arready = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'h11112222;
        smp(); check("s2_d_data_ok", 32'(data_ok), 32'h2);
        check("s2_d_rdata", rdata, 32'h11112222);
        check("s2_inst_wait_r", 32'(addr_ok), 32'h0);
        cyc(); axi_rvalid = 1'b0;
        smp(); check("s2_inst_grant", 32'(addr_ok), 32'h1);
        cyc(); req = 2'b00; axi_arready = 1'b1;
        smp(); check("s2_i_araddr", axi_araddr, 32'h1c000010);
        cyc(); axi_arready = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'h33334444;
        smp(); check("s2_i_data_ok", 32'(data_ok), 32'h1);
        check("s2_i_rdata", rdata, 32'h33334444);
        cyc(); axi_rvalid = 1'b0;

        // 3: data write, W accepted at once, AW after three cycles
        cyc(); req = 2'b10; wr = 2'b10; addr = {32'h1c010006, 32'h0};
        wstrb = {4'b0100, 4'b0}; wdata = {32'h00ab0000, 32'h0}; axi_wready = 1'b1;
        smp(); check("s3_addr_ok", 32'(addr_ok), 32'h2);
        cyc(); idle_inputs(); axi_wready = 1'b1;
        smp(); check("s3_awvalid1", 32'(axi_awvalid), 32'h1);
        check("s3_wvalid1", 32'(axi_wvalid), 32'h1);
        check("s3_awaddr", axi_awaddr, 32'h1c010004);
        check("s3_wdata", axi_wdata, 32'h00ab0000);
        check("s3_wstrb", 32'(axi_wstrb), 32'h4);
        cyc();
        smp(); check("s3_awvalid2", 32'(axi_awvalid), 32'h1);
        check("s3_wvalid_drop", 32'(axi_wvalid), 32'h0);
        cyc(); axi_awready = 1'b1;
        smp(); check("s3_awvalid3", 32'(axi_awvalid), 32'h1);
        cyc(); axi_awready = 1'b0; axi_wready = 1'b0;
        smp(); check("s3_awvalid_drop", 32'(axi_awvalid), 32'h0);
        check("s3_bready", 32'(axi_bready), 32'h1);
        check("s3_no_early_ok", 32'(data_ok), 32'h0);
        cyc(); axi_bvalid = 1'b1;
        smp(); check("s3_data_ok", 32'(data_ok), 32'h2);
        cyc(); axi_bvalid = 1'b0;
        smp(); check("s3_bready_drop", 32'(axi_bready), 32'h0);
        check("s3_single_pulse", 32'(data_ok), 32'h0);

        // 4: pending write blocks a data read of the same word; inst still flows
        cyc(); req = 2'b10; wr = 2'b10; addr = {32'h1c010004, 32'h0};
        wstrb = 8'hf0; wdata = {32'hdeadbeef, 32'h0};
        smp(); check("s4_wr_accept", 32'(addr_ok), 32'h2);
        cyc(); req = 2'b11; wr = 2'b00; addr = {32'h1c010004, 32'h1c000020};
        smp(); check("s4_raw_block", 32'(addr_ok), 32'h1);
        cyc(); req = 2'b10; axi_arready = 1'b1;
        smp(); check("s4_i_araddr", axi_araddr, 32'h1c000020);
        cyc(); axi_arready = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'hcafe0001;
        smp(); check("s4_i_data_ok", 32'(data_ok), 32'h1);
        check("s4_i_rdata", rdata, 32'hcafe0001);
        cyc(); axi_rvalid = 1'b0; axi_awready = 1'b1; axi_wready = 1'b1;
        smp(); check("s4_still_blocked", 32'(addr_ok), 32'h0);
        check("s4_aw_w_together", {axi_awvalid, axi_wvalid}, 32'h3);
        cyc(); axi_awready = 1'b0; axi_wready = 1'b0;
        smp(); check("s4_bready", 32'(axi_bready), 32'h1);
        check("s4_blocked_in_b", 32'(addr_ok), 32'h0);
        cyc(); axi_bvalid = 1'b1;
        smp(); check("s4_w_data_ok", 32'(data_ok), 32'h2);
        check("s4_blocked_at_b", 32'(addr_ok), 32'h0);
        cyc(); axi_bvalid = 1'b0;
        smp(); check("s4_unblocked", 32'(addr_ok), 32'h2);
        cyc(); req = 2'b00; axi_arready = 1'b1;
        smp(); check("s4_d_araddr", axi_araddr, 32'h1c010004);
        cyc(); axi_arready = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'hdeadbeef;
        smp(); check("s4_d_data_ok", 32'(data_ok), 32'h2);
        cyc(); axi_rvalid = 1'b0;

        // 5: reset during R_R, then during W_AW
        cyc(); req = 2'b01; wr = 2'b00; addr = {32'h0, 32'h1c000040};
        cyc(); req = 2'b00; axi_arready = 1'b1;
        cyc(); axi_arready = 1'b0;
        smp(); check("s5_in_rr", 32'(axi_rready), 32'h1);
        #2; reset = 1'b1; #1;
        check("s5_rr_rready", 32'(axi_rready), 32'h0);
        check("s5_rr_arvalid", 32'(axi_arvalid), 32'h0);
        cyc(); reset = 1'b0;
        cyc(); req = 2'b10; wr = 2'b10; addr = {32'h1c030000, 32'h0}; wstrb = 8'hf0;
        cyc(); idle_inputs();
        smp(); check("s5_in_waw", {axi_awvalid, axi_wvalid}, 32'h3);
        #2; reset = 1'b1; #1;
        check("s5_aw_valids", {axi_awvalid, axi_wvalid, axi_bready}, 32'h0);
        check("s5_aw_awaddr", axi_awaddr, 32'h0);
        cyc(); reset = 1'b0;
        inst_read("s5_after", 32'h1c000000, 32'h02800c0c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
